// File: rtl/subleq_core_pkg.sv
// Shared definitions for the SUBLEQ core: controller state encoding and
// helpers that classify states by the bus transaction they belong to.
package subleq_core_pkg;

  localparam int STATE_BITS = 4;

  typedef enum logic [STATE_BITS-1:0] {
    IDLE       = 4'd0,
    FETCH_A    = 4'd1,
    WAIT_A     = 4'd2,
    FETCH_B    = 4'd3,
    WAIT_B     = 4'd4,
    FETCH_C    = 4'd5,
    WAIT_C     = 4'd6,
    DEREF_A    = 4'd7,
    WAIT_DA    = 4'd8,
    DEREF_B    = 4'd9,
    WAIT_DB    = 4'd10,
    STORE      = 4'd11,
    WAIT_STORE = 4'd12,
    BRANCH     = 4'd13,
    HALT       = 4'd14
  } state_t;

  // First cycle of a transaction: the only cycle that raises req.
  function automatic logic is_issue(input state_t s);
    return (s == FETCH_A) || (s == FETCH_B) || (s == FETCH_C) ||
           (s == DEREF_A) || (s == DEREF_B) || (s == STORE);
  endfunction

  function automatic logic is_read(input state_t s);
    return (s == FETCH_A) || (s == WAIT_A) || (s == FETCH_B) || (s == WAIT_B) ||
           (s == FETCH_C) || (s == WAIT_C) || (s == DEREF_A) || (s == WAIT_DA) ||
           (s == DEREF_B) || (s == WAIT_DB);
  endfunction

  function automatic logic is_write(input state_t s);
    return (s == STORE) || (s == WAIT_STORE);
  endfunction

endpackage

// File: rtl/subleq_core_ctrl.sv
// Instruction-sequencing FSM of the SUBLEQ core. Walks the six bus
// transactions of one instruction and decides run/step/halt at the boundary.
module subleq_core_ctrl
  import subleq_core_pkg::*;
#(
  parameter int HALT_ON_SELF_LOOP = 1
) (
  input  logic   clk,
  input  logic   areset,
  input  logic   run,
  input  logic   step,
  input  logic   halt,
  input  logic   ack,
  input  logic   leq,
  input  logic   self_loop,
  output state_t state
);

  localparam bit HaltOnLoop = (HALT_ON_SELF_LOOP != 0);

  state_t r_state;
  logic   r_halt_pend;

  assign state = r_state;

  always_ff @(posedge clk) begin
    if (areset) begin
      r_state     <= IDLE;
      r_halt_pend <= 1'b0;
    end else begin
      // A halt request seen mid-instruction is remembered until the boundary.
      if (halt) r_halt_pend <= 1'b1;
      unique case (r_state)
        IDLE: begin
          if (halt || r_halt_pend)  r_state <= HALT;
          else if (run || step)     r_state <= FETCH_A;
        end
        FETCH_A:    r_state <= ack ? FETCH_B : WAIT_A;
        WAIT_A:     if (ack) r_state <= FETCH_B;
        FETCH_B:    r_state <= ack ? FETCH_C : WAIT_B;
        WAIT_B:     if (ack) r_state <= FETCH_C;
        FETCH_C:    r_state <= ack ? DEREF_A : WAIT_C;
        WAIT_C:     if (ack) r_state <= DEREF_A;
        DEREF_A:    r_state <= ack ? DEREF_B : WAIT_DA;
        WAIT_DA:    if (ack) r_state <= DEREF_B;
        DEREF_B:    r_state <= ack ? STORE : WAIT_DB;
        WAIT_DB:    if (ack) r_state <= STORE;
        STORE:      r_state <= ack ? BRANCH : WAIT_STORE;
        WAIT_STORE: if (ack) r_state <= BRANCH;
        BRANCH:     r_state <= (HaltOnLoop && leq && self_loop) ? HALT : IDLE;
        HALT:       r_state <= HALT;
        default:    r_state <= IDLE;
      endcase
    end
  end

endmodule

// File: rtl/subleq_core.sv
// SUBLEQ processor core: mem[B] <- mem[B] - mem[A]; branch to C when the
// result is <= 0. Datapath, retire counter and bus decoding live here.
module subleq_core
  import subleq_core_pkg::*;
#(
  parameter int WORD_SIZE         = 16,
  parameter int RESET_PC          = 0,
  parameter int COUNT_WIDTH       = 32,
  parameter int HALT_ON_SELF_LOOP = 1
) (
  input  logic                   clk,
  input  logic                   areset,
  input  logic                   run,
  input  logic                   step,
  input  logic                   halt,
  input  logic                   ack,
  input  logic [WORD_SIZE-1:0]   data_in,
  output logic                   req,
  output logic                   load,
  output logic                   store,
  output logic [WORD_SIZE-1:0]   addr,
  output logic [WORD_SIZE-1:0]   data_out,
  output logic                   halted,
  output logic [COUNT_WIDTH-1:0] retired
);

  localparam logic [WORD_SIZE-1:0] PcInit = WORD_SIZE'(RESET_PC);

  logic [WORD_SIZE-1:0]   r_pc;
  logic [WORD_SIZE-1:0]   r_ptr_a;
  logic [WORD_SIZE-1:0]   r_ptr_b;
  logic [WORD_SIZE-1:0]   r_ptr_c;
  logic [WORD_SIZE-1:0]   r_a;
  logic [WORD_SIZE-1:0]   r_result;
  logic [COUNT_WIDTH-1:0] r_retired;

  state_t                 w_state;
  logic                   w_leq;
  logic                   w_self_loop;
  logic [WORD_SIZE-1:0]   w_addr;

  function automatic logic [WORD_SIZE-1:0] sub_wrap(input logic [WORD_SIZE-1:0] b,
                                                    input logic [WORD_SIZE-1:0] a);
    logic signed [WORD_SIZE-1:0] diff;
    diff = $signed(b) - $signed(a);
    return diff;
  endfunction

  function automatic logic is_leq(input logic signed [WORD_SIZE-1:0] v);
    return v[WORD_SIZE-1] || (v == '0);
  endfunction

  assign w_leq       = is_leq(r_result);
  assign w_self_loop = (r_ptr_c == r_pc);

  subleq_core_ctrl #(
    .HALT_ON_SELF_LOOP (HALT_ON_SELF_LOOP)
  ) u_ctrl (
    .clk       (clk),
    .areset    (areset),
    .run       (run),
    .step      (step),
    .halt      (halt),
    .ack       (ack),
    .leq       (w_leq),
    .self_loop (w_self_loop),
    .state     (w_state)
  );

  // b is only needed to form the difference, so it goes straight into the
  // result register in its ack cycle rather than being held separately.
  always_ff @(posedge clk) begin
    if (areset) begin
      r_pc      <= PcInit;
      r_ptr_a   <= '0;
      r_ptr_b   <= '0;
      r_ptr_c   <= '0;
      r_a       <= '0;
      r_result  <= '0;
      r_retired <= '0;
    end else begin
      unique case (w_state)
        FETCH_A, WAIT_A:    if (ack) r_ptr_a <= data_in;
        FETCH_B, WAIT_B:    if (ack) r_ptr_b <= data_in;
        FETCH_C, WAIT_C:    if (ack) r_ptr_c <= data_in;
        DEREF_A, WAIT_DA:   if (ack) r_a <= data_in;
        DEREF_B, WAIT_DB:   if (ack) r_result <= sub_wrap(data_in, r_a);
        BRANCH: begin
          r_pc      <= w_leq ? r_ptr_c : r_pc + WORD_SIZE'(3);
          r_retired <= r_retired + COUNT_WIDTH'(1);
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    w_addr = '0;
    unique case (w_state)
      FETCH_A, WAIT_A:     w_addr = r_pc;
      FETCH_B, WAIT_B:     w_addr = r_pc + WORD_SIZE'(1);
      FETCH_C, WAIT_C:     w_addr = r_pc + WORD_SIZE'(2);
      DEREF_A, WAIT_DA:    w_addr = r_ptr_a;
      DEREF_B, WAIT_DB:    w_addr = r_ptr_b;
      STORE, WAIT_STORE:   w_addr = r_ptr_b;
      HALT:                w_addr = '1;
      default:             w_addr = '0;
    endcase
  end

  assign req      = is_issue(w_state);
  assign load     = is_read(w_state);
  assign store    = is_write(w_state);
  assign addr     = w_addr;
  assign data_out = r_result;
  assign halted   = (w_state == HALT);
  assign retired  = r_retired;

endmodule

// File: tb/tb_subleq_core.sv
// Directed bench for subleq_core: a behavioural memory answers the bus with
// programmable ack latency while each task drives one scenario and checks it.
module tb_subleq_core;

  localparam int W = 16;

  logic          clk = 1'b0;
  logic          areset = 1'b1;
  logic          run = 1'b0;
  logic          step = 1'b0;
  logic          halt = 1'b0;
  logic          ack = 1'b0;
  logic [W-1:0]  data_in = '0;
  logic          req, load, store, halted;
  logic [W-1:0]  addr, data_out;
  logic [31:0]   retired;

  logic [W-1:0]  mem [0:65535];
  logic [W-1:0]  ref_m [0:127];
  logic [W-1:0]  addr_log [$];

  int n_vec = 0;
  int n_err = 0;
  int viol = 0;
  int n_req = 0;
  int n_ack = 0;
  int n_store = 0;
  int fixed_delay = 0;
  bit rand_delay = 1'b0;

  always #5 clk = ~clk;

  subleq_core #(
    .WORD_SIZE (W), .RESET_PC (0), .COUNT_WIDTH (32), .HALT_ON_SELF_LOOP (1)
  ) dut (
    .clk (clk), .areset (areset), .run (run), .step (step), .halt (halt),
    .ack (ack), .data_in (data_in), .req (req), .load (load), .store (store),
    .addr (addr), .data_out (data_out), .halted (halted), .retired (retired)
  );

  // Memory responder: acts on the falling edge, watches protocol stability.
  initial begin
    bit           act;
    int           rem;
    logic [W-1:0] s_addr, s_dout;
    logic         s_load, s_store;
    act = 1'b0; rem = 0; s_addr = '0; s_dout = '0; s_load = 1'b0; s_store = 1'b0;
    forever begin
      @(negedge clk);
      ack = 1'b0;
      data_in = W'($urandom);
      if (!load && !store) act = 1'b0;
      if (req) begin
        if (act) viol++;
        act = 1'b1; s_addr = addr; s_load = load; s_store = store; s_dout = data_out;
        rem = rand_delay ? int'($urandom_range(0, 3)) : fixed_delay;
        n_req++;
        addr_log.push_back(addr);
      end else if (act) begin
        if (addr !== s_addr || load !== s_load || store !== s_store || data_out !== s_dout)
          viol++;
      end
      if (act) begin
        if (rem == 0) begin
          ack = 1'b1;
          n_ack++;
          if (s_load) data_in = mem[s_addr];
          else begin mem[s_addr] = s_dout; n_store++; end
          act = 1'b0;
        end else rem--;
      end
    end
  end

  initial begin
    #600000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  task automatic tick();
    @(posedge clk);
    #2;
  endtask

  task automatic mem_clear();
    for (int i = 0; i < 65536; i++) mem[i] = '0;
  endtask

  task automatic do_reset();
    areset = 1'b1; run = 1'b0; step = 1'b0; halt = 1'b0;
    fixed_delay = 0; rand_delay = 1'b0;
    repeat (3) tick();
    areset = 1'b0;
  endtask

  // Pulses step and returns the address of the first fetch it triggers.
  task automatic next_fetch(output logic [W-1:0] a, output bit ok);
    ok = 1'b0; a = '0;
    step = 1'b1;
    for (int i = 0; i < 20; i++) begin
      tick();
      step = 1'b0;
      if (req) begin a = addr; ok = 1'b1; break; end
    end
    step = 1'b0;
  endtask

  task automatic wait_retired(input logic [31:0] target, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < 400; i++) begin
      if (retired == target) begin ok = 1'b1; break; end
      tick();
    end
  endtask

  task automatic test_reset();
    areset = 1'b1; run = 1'b1;
    repeat (3) tick();
    areset = 1'b0; run = 1'b0;
    n_vec++;
    if ({req, load, store, halted} !== 4'b0000) begin
      n_err++; $display("FAIL reset_ctrl: got %b expected 0000", {req, load, store, halted});
    end
    n_vec++;
    if (addr !== 16'h0000) begin n_err++; $display("FAIL reset_addr: got %h expected 0000", addr); end
    n_vec++;
    if (data_out !== 16'h0000) begin n_err++; $display("FAIL reset_dout: got %h expected 0000", data_out); end
    n_vec++;
    if (retired !== 32'd0) begin n_err++; $display("FAIL reset_retired: got %0d expected 0", retired); end
  endtask

  task automatic test_basic();
    int cyc; bit ok; logic [W-1:0] fa;
    mem_clear();
    mem[0] = 16'd3; mem[1] = 16'd4; mem[2] = 16'd0; mem[3] = 16'd2; mem[4] = 16'd5;
    do_reset();
    cyc = 0;
    step = 1'b1;
    while (retired == 32'd0 && cyc < 50) begin tick(); step = 1'b0; cyc++; end
    n_vec++;
    if (cyc != 8) begin n_err++; $display("FAIL basic_cycles: got %0d expected 8", cyc); end
    n_vec++;
    if (retired !== 32'd1) begin n_err++; $display("FAIL basic_retired: got %0d expected 1", retired); end
    n_vec++;
    if (mem[4] !== 16'd3) begin n_err++; $display("FAIL basic_store: got %h expected 0003", mem[4]); end
    n_vec++;
    if (data_out !== 16'd3) begin n_err++; $display("FAIL basic_dout: got %h expected 0003", data_out); end
    next_fetch(fa, ok);
    n_vec++;
    if (!ok || fa !== 16'd3) begin n_err++; $display("FAIL basic_pc: got %h ok=%0d expected 0003", fa, ok); end
    wait_retired(32'd2, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL basic_second: got retired %0d expected 2", retired); end
  endtask

  task automatic test_self_loop();
    int cyc;
    mem_clear();
    mem[0] = 16'd6; mem[1] = 16'd6; mem[2] = 16'd0; mem[6] = 16'd7;
    do_reset();
    run = 1'b1;
    cyc = 0;
    while (!halted && cyc < 60) begin tick(); cyc++; end
    n_vec++;
    if (halted !== 1'b1) begin n_err++; $display("FAIL loop_halted: got %b expected 1", halted); end
    n_vec++;
    if (addr !== 16'hFFFF) begin n_err++; $display("FAIL loop_addr: got %h expected ffff", addr); end
    n_vec++;
    if (retired !== 32'd1) begin n_err++; $display("FAIL loop_retired: got %0d expected 1", retired); end
    n_vec++;
    if (mem[6] !== 16'd0) begin n_err++; $display("FAIL loop_store: got %h expected 0000", mem[6]); end
    repeat (5) tick();
    n_vec++;
    if ({halted, req, load, store} !== 4'b1000 || retired !== 32'd1) begin
      n_err++; $display("FAIL loop_absorb: got %b/%0d expected 1000/1", {halted, req, load, store}, retired);
    end
    run = 1'b0;
  endtask

  task automatic test_step();
    mem_clear();
    for (int k = 0; k < 3; k++) begin
      mem[3*k] = 16'd10; mem[3*k+1] = 16'd11; mem[3*k+2] = 16'd0;
    end
    mem[10] = 16'd1; mem[11] = 16'd100;
    do_reset();
    for (int k = 1; k <= 3; k++) begin
      step = 1'b1;
      tick();
      step = 1'b0;
      repeat (19) tick();
      n_vec++;
      if (retired !== 32'(k)) begin n_err++; $display("FAIL step_retired%0d: got %0d expected %0d", k, retired, k); end
      n_vec++;
      if ({req, load, store, halted} !== 4'b0000) begin
        n_err++; $display("FAIL step_idle%0d: got %b expected 0000", k, {req, load, store, halted});
      end
    end
    n_vec++;
    if (mem[11] !== 16'd97) begin n_err++; $display("FAIL step_mem: got %0d expected 97", mem[11]); end
  endtask

  task automatic test_wrap();
    bit ok; logic [W-1:0] fa;
    mem_clear();
    mem[0] = 16'd20; mem[1] = 16'd20; mem[2] = 16'hFFFE; mem[20] = 16'd5;
    mem[16'hFFFE] = 16'h0030; mem[16'hFFFF] = 16'h0031;
    mem[16'h0030] = 16'h0001; mem[16'h0031] = 16'h8000;
    do_reset();
    step = 1'b1; tick(); step = 1'b0;
    wait_retired(32'd1, ok);
    addr_log.delete();
    step = 1'b1; tick(); step = 1'b0;
    wait_retired(32'd2, ok);
    n_vec++;
    if (!ok) begin n_err++; $display("FAIL wrap_done: got retired %0d expected 2", retired); end
    n_vec++;
    if (addr_log.size() < 3 || addr_log[0] !== 16'hFFFE || addr_log[2] !== 16'h0000) begin
      n_err++; $display("FAIL wrap_fetch_c: got %0d entries expected fffe,ffff,0000", addr_log.size());
    end
    n_vec++;
    if (mem[16'h0031] !== 16'h7FFF) begin n_err++; $display("FAIL wrap_store: got %h expected 7fff", mem[16'h0031]); end
    n_vec++;
    if (data_out !== 16'h7FFF) begin n_err++; $display("FAIL wrap_dout: got %h expected 7fff", data_out); end
    next_fetch(fa, ok);
    n_vec++;
    if (!ok || fa !== 16'h0001) begin n_err++; $display("FAIL wrap_pc: got %h ok=%0d expected 0001", fa, ok); end
    wait_retired(32'd3, ok);
  endtask

  task automatic test_areset_wait_db();
    bit ok; int nr; logic [W-1:0] fa;
    mem_clear();
    mem[0] = 16'd10; mem[1] = 16'd11; mem[2] = 16'd0;
    mem[3] = 16'd10; mem[4] = 16'd11; mem[5] = 16'd0;
    mem[10] = 16'd1; mem[11] = 16'd9;
    do_reset();
    step = 1'b1; tick(); step = 1'b0;
    wait_retired(32'd1, ok);
    fixed_delay = 5;
    nr = 0;
    step = 1'b1;
    for (int i = 0; i < 100 && nr < 5; i++) begin
      tick(); step = 1'b0;
      if (req) nr++;
    end
    tick();
    n_vec++;
    if ({req, load} !== 2'b01 || addr !== 16'd11) begin
      n_err++; $display("FAIL ares_in_wait_db: got req/load %b addr %h expected 01/000b", {req, load}, addr);
    end
    areset = 1'b1;
    tick();
    n_vec++;
    if ({req, load, store} !== 3'b000) begin
      n_err++; $display("FAIL ares_bus: got %b expected 000", {req, load, store});
    end
    areset = 1'b0;
    n_vec++;
    if (retired !== 32'd0) begin n_err++; $display("FAIL ares_retired: got %0d expected 0", retired); end
    fixed_delay = 0;
    next_fetch(fa, ok);
    n_vec++;
    if (!ok || fa !== 16'd0) begin n_err++; $display("FAIL ares_pc: got %h ok=%0d expected 0000", fa, ok); end
    n_vec++;
    if (mem[11] !== 16'd8) begin n_err++; $display("FAIL ares_mem: got %0d expected 8", mem[11]); end
    wait_retired(32'd1, ok);
  endtask

  task automatic test_halt_mid();
    int nr; int st0; int cyc;
    mem_clear();
    mem[0] = 16'd10; mem[1] = 16'd11; mem[2] = 16'd0;
    mem[10] = 16'd1; mem[11] = 16'd9;
    do_reset();
    fixed_delay = 2;
    st0 = n_store;
    nr = 0;
    step = 1'b1;
    for (int i = 0; i < 50 && nr < 2; i++) begin
      tick(); step = 1'b0;
      if (req) nr++;
    end
    tick();
    halt = 1'b1;
    cyc = 0;
    while (!halted && cyc < 100) begin tick(); cyc++; end
    n_vec++;
    if (halted !== 1'b1) begin n_err++; $display("FAIL halt_halted: got %b expected 1", halted); end
    n_vec++;
    if (mem[11] !== 16'd8 || n_store - st0 != 1) begin
      n_err++; $display("FAIL halt_store: got %0d (%0d stores) expected 8 (1)", mem[11], n_store - st0);
    end
    n_vec++;
    if (retired !== 32'd1) begin n_err++; $display("FAIL halt_retired: got %0d expected 1", retired); end
    halt = 1'b0; run = 1'b1;
    repeat (5) tick();
    n_vec++;
    if (halted !== 1'b1 || addr !== 16'hFFFF || retired !== 32'd1) begin
      n_err++; $display("FAIL halt_absorb: got %b %h %0d expected 1 ffff 1", halted, addr, retired);
    end
    run = 1'b0;
  endtask

  task automatic test_random();
    logic [W-1:0] pc, pa, pb, pc_c, r;
    int cyc, q0, a0, mism;
    mem_clear();
    for (int i = 0; i < 20; i++) begin
      pa = W'(100 + $urandom_range(0, 15));
      pb = W'(100 + $urandom_range(0, 15));
      if (i == 19) pb = pa;
      do pc_c = W'(3 * $urandom_range(0, 19)); while (pc_c == W'(3 * i));
      mem[3*i] = pa; mem[3*i+1] = pb; mem[3*i+2] = pc_c;
    end
    for (int d = 100; d < 116; d++) mem[d] = W'($urandom);
    mem[100] = 16'h8000; mem[101] = 16'h0001;
    for (int i = 0; i < 128; i++) ref_m[i] = mem[i];
    pc = '0; r = '0;
    for (int n = 0; n < 50; n++) begin
      pa = ref_m[pc]; pb = ref_m[pc + 1]; pc_c = ref_m[pc + 2];
      r = ref_m[pb] - ref_m[pa];
      ref_m[pb] = r;
      pc = ($signed(r) <= 16'sd0) ? pc_c : pc + 16'd3;
    end
    do_reset();
    rand_delay = 1'b1;
    viol = 0; q0 = n_req; a0 = n_ack;
    run = 1'b1;
    cyc = 0;
    while (retired != 32'd50 && cyc < 4000) begin tick(); cyc++; end
    run = 1'b0;
    repeat (4) tick();
    n_vec++;
    if (retired !== 32'd50) begin n_err++; $display("FAIL rand_retired: got %0d expected 50", retired); end
    n_vec++;
    if (viol != 0) begin n_err++; $display("FAIL rand_protocol: got %0d violations expected 0", viol); end
    n_vec++;
    if (n_req - q0 != 300 || n_ack - a0 != 300) begin
      n_err++; $display("FAIL rand_reqs: got %0d req %0d ack expected 300", n_req - q0, n_ack - a0);
    end
    mism = 0;
    for (int d = 100; d < 116; d++) if (mem[d] !== ref_m[d]) mism++;
    n_vec++;
    if (mism != 0) begin n_err++; $display("FAIL rand_mem: got %0d differing words expected 0", mism); end
    n_vec++;
    if (data_out !== r) begin n_err++; $display("FAIL rand_dout: got %h expected %h", data_out, r); end
    rand_delay = 1'b0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_self_loop();
    test_step();
    test_wrap();
    test_areset_wait_db();
    test_halt_mid();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
